bit_permute_pipe: RTL and testbench

Registered, handshaked successor to the combinational word reverser. Applies one of four runtime-selectable bit permutations to a WORD_WIDTH word:
- pass-through
- full bit reverse
- group-order reverse (byte swap when GROUP_WIDTH=8)
- bit reverse inside each group

Sits on valid/ready datapaths in the std utils library, e.g. endianness conversion between bus and peripheral, CRC/FFT bit-order fixups.

---
 rtl/bit_permute_pipe.sv | 174 +++++++++++++++++
 tb/tb_bit_permute_pipe.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_permute_pipe.sv
// bit_permute_pipe: registered valid/ready bit permuter.
//   mode 0 pass, 1 full bit reverse, 2 group-order reverse, 3 bit reverse
//   inside each GROUP_WIDTH group. One cycle latency, full throughput.
// Optional macro BIT_PERMUTE_PIPE_SKID_EN adds a one-entry skid register
// so that in_ready becomes a pure register output (up to 2 words held).
module bit_permute_pipe #(
    parameter int WORD_WIDTH  = 32,
    parameter int GROUP_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] in_data,
    input  logic [1:0]            in_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] out_data,
    output logic [1:0]            out_mode
);

    // Guarded group size so the index arithmetic below never divides by zero
    // even when the parameter check is about to reject the configuration.
    localparam int G = (GROUP_WIDTH >= 1) ? GROUP_WIDTH : 1;
    localparam int K = WORD_WIDTH / G;
    localparam bit CFG_OK = (WORD_WIDTH >= 1) && (GROUP_WIDTH >= 1) &&
                            ((WORD_WIDTH % G) == 0);

    generate
        if (WORD_WIDTH < 1) begin : g_bad_word
            $error("bit_permute_pipe: WORD_WIDTH (%0d) must be >= 1", WORD_WIDTH);
        end
        if (GROUP_WIDTH < 1 || (WORD_WIDTH % G) != 0) begin : g_bad_group
            $error("bit_permute_pipe: GROUP_WIDTH (%0d) must be >= 1 and divide WORD_WIDTH (%0d)",
                   GROUP_WIDTH, WORD_WIDTH);
        end
    endgenerate

    // ------------------------------------------------------------------
    // Permutation network: pure wiring, one candidate per mode.
    // ------------------------------------------------------------------
    logic [WORD_WIDTH-1:0] rev_w;   // mode 1
    logic [WORD_WIDTH-1:0] grp_w;   // mode 2
    logic [WORD_WIDTH-1:0] igr_w;   // mode 3
    logic [WORD_WIDTH-1:0] perm_w;

    generate
        if (CFG_OK) begin : g_perm
            for (genvar i = 0; i < WORD_WIDTH; i++) begin : g_bit
                localparam int J = i / G;   // group holding output bit i
                localparam int B = i % G;   // position inside that group
                assign rev_w[i] = in_data[WORD_WIDTH-1-i];
                assign grp_w[i] = in_data[(K-1-J)*G + B];
                assign igr_w[i] = in_data[J*G + G-1-B];
            end
        end else begin : g_noperm
            assign rev_w = '0;
            assign grp_w = '0;
            assign igr_w = '0;
        end
    endgenerate

    // Select the candidate for the mode presented with the input word.
    always_comb begin
        perm_w = in_data;
        case (in_mode)
            2'd1:    perm_w = rev_w;
            2'd2:    perm_w = grp_w;
            2'd3:    perm_w = igr_w;
            default: perm_w = in_data;
        endcase
    end

    // ------------------------------------------------------------------
    // Output stage (and optional skid stage)
    // ------------------------------------------------------------------
    logic                  out_valid_q, out_valid_d;
    logic [WORD_WIDTH-1:0] out_data_q,  out_data_d;
    logic [1:0]            out_mode_q,  out_mode_d;
    logic                  in_xfer;
    logic                  out_xfer;

    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid_q && out_ready;

`ifdef BIT_PERMUTE_PIPE_SKID_EN
    logic                  skid_valid_q, skid_valid_d;
    logic [WORD_WIDTH-1:0] skid_data_q,  skid_data_d;
    logic [1:0]            skid_mode_q,  skid_mode_d;
    logic                  out_free;

    // Output register can take a new word this edge.
    assign out_free = !out_valid_q || out_ready;
    // Accept only while the skid slot is empty: no path from out_ready.
    assign in_ready = !skid_valid_q;

    // Next-state: the skid word has priority into the output register;
    // an input arriving while the output is stalled parks in the skid.
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_mode_d   = out_mode_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_mode_d  = skid_mode_q;
        if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                out_mode_d   = skid_mode_q;
                skid_valid_d = 1'b0;
            end else if (in_xfer) begin
                out_valid_d = 1'b1;
                out_data_d  = perm_w;
                out_mode_d  = in_mode;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (in_xfer) begin
            skid_valid_d = 1'b1;
            skid_data_d  = perm_w;
            skid_mode_d  = in_mode;
        end
    end

    // Skid register state; cleared asynchronously so held words are dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_mode_q  <= 2'd0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_mode_q  <= skid_mode_d;
        end
    end
`else
    // Single register: accept when empty or when it drains this same edge.
    assign in_ready = !out_valid_q || out_ready;

    // Next-state: load on input, empty on a bare output transfer, else hold.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_mode_d  = out_mode_q;
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = perm_w;
            out_mode_d  = in_mode;
        end else if (out_xfer) begin
            out_valid_d = 1'b0;
        end
    end
`endif

    // Output register state; reset drops out_valid immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_mode_q  <= 2'd0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_mode_q  <= out_mode_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_mode  = out_mode_q;

endmodule

// File: tb/tb_bit_permute_pipe.sv
// Directed bench for bit_permute_pipe (32/8 main instance, 12/4 side instance).
module tb_bit_permute_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_data, out_data;
    logic [1:0]  in_mode, out_mode;

    logic        v12, rdy12, ov12, or12;
    logic [11:0] d12, od12;
    logic [1:0]  m12, om12;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bit_permute_pipe #(.WORD_WIDTH(32), .GROUP_WIDTH(8)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mode(out_mode)
    );

    bit_permute_pipe #(.WORD_WIDTH(12), .GROUP_WIDTH(4)) u_dut12 (
        .clk(clk), .rst(rst),
        .in_valid(v12), .in_ready(rdy12), .in_data(d12), .in_mode(m12),
        .out_valid(ov12), .out_ready(or12), .out_data(od12), .out_mode(om12)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference permutation for N=32, G=8 built from streaming operators.
    function automatic logic [31:0] perm32(input logic [31:0] d, input logic [1:0] m);
        logic [31:0] t;
        logic [31:0] r;
        case (m)
            2'd0: r = d;
            2'd1: r = {<<{d}};
            2'd2: r = {<<8{d}};
            default: begin
                t = {<<{d}};
                r = {<<8{t}};
            end
        endcase
        return r;
    endfunction

    logic [31:0] dir_exp [4];
    logic [31:0] pd, ed;
    logic [1:0]  pm, em;
    logic [33:0] q [$];
    logic [33:0] ent;
    int          sent, recv, cycles;

    initial begin
        dir_exp[0] = 32'h12345678;
        dir_exp[1] = 32'h1E6A2C48;
        dir_exp[2] = 32'h78563412;
        dir_exp[3] = 32'h482C6A1E;
        in_valid = 1'b0; in_data = '0; in_mode = 2'd0; out_ready = 1'b1;
        v12 = 1'b0; d12 = '0; m12 = 2'd0; or12 = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        check("post_rst_out_mode", 32'(out_mode), 32'd0);

        // Four modes on 0x12345678, back to back
        @(negedge clk);
        in_valid = 1'b1; in_data = 32'h12345678; in_mode = 2'd0;
        for (int m = 0; m < 4; m++) begin
            @(negedge clk);
            #1;
            check("dir_valid", 32'(out_valid), 32'd1);
            check("dir_data", out_data, dir_exp[m]);
            check("dir_mode", 32'(out_mode), 32'(m));
            if (m < 3) in_mode = 2'(m + 1);
            else       in_valid = 1'b0;
        end
        @(negedge clk);
        #1;
        check("dir_drained", 32'(out_valid), 32'd0);

        // Stall: A5A5A5A5 mode 1 held while out_ready=0
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5A5A5; in_mode = 2'd1;
        @(negedge clk);
        #1;
        check("stall_first_data", out_data, 32'hA5A5A5A5);
        check("stall_first_mode", 32'(out_mode), 32'd1);
        in_data = 32'h0000FFFF; in_mode = 2'd0;
        #1;
`ifdef BIT_PERMUTE_PIPE_SKID_EN
        check("stall_skid_accept", 32'(in_ready), 32'd1);
`else
        check("stall_ready_low", 32'(in_ready), 32'd0);
`endif
        for (int i = 2; i <= 6; i++) begin
            @(negedge clk);
            #1;
`ifdef BIT_PERMUTE_PIPE_SKID_EN
            if (i == 2) in_valid = 1'b0;
`endif
            check("stall_valid", 32'(out_valid), 32'd1);
            check("stall_data", out_data, 32'hA5A5A5A5);
            check("stall_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        #1;
`ifdef BIT_PERMUTE_PIPE_SKID_EN
        check("release_ready", 32'(in_ready), 32'd0);
`else
        check("release_ready", 32'(in_ready), 32'd1);
`endif
        @(negedge clk);
        #1;
        in_valid = 1'b0;
        check("drain2_valid", 32'(out_valid), 32'd1);
        check("drain2_data", out_data, 32'h0000FFFF);
        check("drain2_mode", 32'(out_mode), 32'd0);
        check("drain2_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        #1;
        check("drain_empty", 32'(out_valid), 32'd0);

        // 100 back-to-back random words, out_ready=1
        pd = '0; pm = 2'd0;
        for (int k = 0; k <= 100; k++) begin
            @(negedge clk);
            #1;
            if (k > 0) begin
                check("b2b_valid", 32'(out_valid), 32'd1);
                check("b2b_data", out_data, perm32(pd, pm));
                check("b2b_mode", 32'(out_mode), 32'(pm));
            end
            if (k < 100) begin
                pd = $urandom; pm = 2'($urandom_range(0, 3));
                in_valid = 1'b1; in_data = pd; in_mode = pm;
            end else begin
                in_valid = 1'b0;
            end
        end
        @(negedge clk);
        #1;
        check("b2b_drained", 32'(out_valid), 32'd0);

        // Random valid/ready toggling, 1000 words, scoreboard
        sent = 0; recv = 0; cycles = 0;
        while (recv < 1000 && cycles < 20000) begin
            @(negedge clk);
            in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
            in_data   = $urandom;
            in_mode   = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 1) == 1);
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("sb_spurious", 32'd1, 32'd0);
                end else begin
                    ent = q.pop_front();
                    ed = ent[31:0]; em = ent[33:32];
                    check("sb_data", out_data, ed);
                    check("sb_mode", 32'(out_mode), 32'(em));
                end
                recv++;
            end
            if (in_valid && in_ready) begin
                q.push_back({in_mode, perm32(in_data, in_mode)});
                sent++;
            end
            cycles++;
        end
        check("sb_recv_count", 32'(recv), 32'd1000);
        check("sb_queue_empty", 32'(q.size()), 32'd0);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("sb_idle", 32'(out_valid), 32'd0);

        // 12-bit instance, G=4
        v12 = 1'b1; d12 = 12'hABC; m12 = 2'd2;
        @(negedge clk);
        #1;
        check("n12_mode2", 32'(od12), 32'h0CBA);
        m12 = 2'd3;
        @(negedge clk);
        #1;
        check("n12_mode3", 32'(od12), 32'h05D3);
        check("n12_omode", 32'(om12), 32'd3);
        v12 = 1'b0;

        // Reset mid-stream with words held
        out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hDEADBEEF; in_mode = 2'd2;
        @(negedge clk);
        in_data = 32'h01234567; in_mode = 2'd3;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("mid_held_valid", 32'(out_valid), 32'd1);
        check("mid_held_data", out_data, 32'hEFBEADDE);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_async_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_post_ready", 32'(in_ready), 32'd1);
        check("mid_post_data", out_data, 32'd0);
        check("mid_post_mode", 32'(out_mode), 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            check("mid_no_stale", 32'(out_valid), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
